// File: rtl/dtree_share_sched.sv
// Round-robin scheduler sharing one slow combinational decision-tree classifier among NCH requesters.
// Define DTREE_SCHED_STATS_EN to add the saturating 16-bit result handshake counter o_res_count.
module dtree_share_sched #(
    parameter int NCH    = 4,
    parameter int FEAT_W = 40,
    parameter int CLS_W  = 5,
    parameter int SETTLE = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NCH-1:0]          i_req_valid,
    output logic [NCH-1:0]          o_req_ready,
    input  logic [NCH*FEAT_W-1:0]   i_req_feat,
    output logic [FEAT_W-1:0]       o_tree_feat,
    input  logic [CLS_W-1:0]        i_tree_class,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [CLS_W-1:0]        o_res_class,
    output logic [$clog2(NCH)-1:0]  o_res_ch
`ifdef DTREE_SCHED_STATS_EN
    ,
    output logic [15:0]             o_res_count
`endif
);

    localparam int CH_W  = $clog2(NCH);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CH_W-1:0]     r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [FEAT_W-1:0]   r_tree_feat;
    logic                r_res_valid;
    logic [CLS_W-1:0]    r_res_class;
    logic [CH_W-1:0]     r_res_ch;
    logic                w_found;
    logic [CH_W-1:0]     w_winner;
    logic [NCH-1:0]      w_req_ready;

    // Scan starts just after the last winner so a persistent requester waits at most NCH-1 grants.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(r_last_grant) + k) % NCH;
            if (!w_found && i_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = CH_W'(idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next_state = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_next_state = S_DONE;
            S_DONE:   if (i_res_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // tree_class is sampled only on the final settle edge, so earlier glitches never reach res_class.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= CH_W'(NCH - 1);
            r_cnt        <= '0;
            r_tree_feat  <= '0;
            r_res_valid  <= 1'b0;
            r_res_class  <= '0;
            r_res_ch     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_tree_feat  <= i_req_feat[w_winner*FEAT_W +: FEAT_W];
                        r_res_ch     <= w_winner;
                        r_last_grant <= w_winner;
                        r_cnt        <= CNT_W'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_res_class <= i_tree_class;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DTREE_SCHED_STATS_EN
    logic [15:0] r_res_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_count <= '0;
        end else if (r_state == S_DONE && i_res_ready && r_res_count != 16'hFFFF) begin
            r_res_count <= r_res_count + 16'd1;
        end
    end

    assign o_res_count = r_res_count;
`endif

    assign o_req_ready = w_req_ready;
    assign o_tree_feat = r_tree_feat;
    assign o_res_valid = r_res_valid;
    assign o_res_class = r_res_class;
    assign o_res_ch    = r_res_ch;

endmodule

// File: doc/dtree_share_sched.md
Name: dtree_share_sched

Overview:
- Round-robin scheduler that time-shares one combinational printed decision-tree classifier among NCH sensor requesters.
- Captures a requester's packed feature vector into a register and drives the tree from it.
- Waits SETTLE cycles for the slow printed logic to resolve, then captures the class code.
- Returns the class code with the originating channel index over a valid/ready result port.

Parameters:
- NCH, 4, number of requester channels (2..8).
- FEAT_W, 40, packed feature width (five 8-bit features).
- CLS_W, 5, class code width from the tree.
- SETTLE, 3, cycles the tree input is held before its output is sampled (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NCH  per-channel request valid.
- req_ready  output  NCH  per-channel accept; at most one bit set.
- req_feat  input  NCH*FEAT_W  per-channel features; channel i occupies bits [i*FEAT_W +: FEAT_W].
- tree_feat  output  FEAT_W  registered features to the classifier.
- tree_class  input  CLS_W  class code from the classifier (combinational from tree_feat).
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_class  output  CLS_W  captured class code.
- res_ch  output  clog2(NCH)  channel that produced res_class.

Behaviour:
- Reset (async, any state) values:
  - state=IDLE; req_ready=0; tree_feat=0; res_valid=0; res_class=0; res_ch=0.
  - last_grant=NCH-1, so channel 0 has top priority first.
  - settle counter=0.
  - Any in-flight request or held result is dropped without notification.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Arbiter scans channels from last_grant+1 upward, wrapping modulo NCH; first asserted req_valid wins.
  - req_ready[winner]=1 combinationally, all other bits 0; req_ready is all-zero outside IDLE.
  - On the edge where req_valid[winner] is high:
    - tree_feat <= req_feat[winner]; res_ch <= winner; last_grant <= winner.
    - counter <= SETTLE-1; state -> SETTLE.
  - No req_valid high: stay in IDLE, no register change.
  - req_valid may drop before grant; the arbiter re-evaluates every cycle.
- SETTLE:
  - tree_feat held stable.
  - Counter decrements each cycle.
  - On the edge where counter==0: res_class <= tree_class; res_valid <= 1; state -> DONE.
- DONE:
  - res_valid, res_class, res_ch and tree_feat all held stable.
  - On the edge with res_ready=1: res_valid <= 0; state -> IDLE.
- Latency and throughput:
  - Request accepted at edge T0; res_valid high in the cycle after edge T0+SETTLE.
  - With res_ready held high, DONE lasts one cycle and IDLE lasts one cycle, so at best one result every SETTLE+2 cycles.
- Fairness: a channel that keeps req_valid asserted waits at most NCH-1 grants.
- res_ready is ignored outside DONE.
- tree_class is only sampled on the final SETTLE edge; glitches before that have no effect.

Optional Feature:
- Macro: DTREE_SCHED_STATS_EN.
- Enabled:
  - Adds output res_count, 16 bits.
  - Increments on each result handshake (res_valid & res_ready).
  - Saturates at 16'hFFFF; reset to 0.
- Disabled: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: after reset, ch2 valid with feat=40'h00_00_00_00_3F, tree_class=5'd7, res_ready=1 -> req_ready=4'b0100 in the first cycle; res_valid rises exactly SETTLE=3 cycles after the accept edge with res_class=7, res_ch=2.
- Round-robin: ch0..ch3 all valid continuously -> grant order 0,1,2,3,0; req_ready is one-hot and only in IDLE; each grant is 5 cycles apart.
- Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_class, res_ch and tree_feat stable; no req_ready during the stall; the next grant comes one cycle after res_ready goes high.
- Settle sampling: tree_class=1 during the first 2 SETTLE cycles, then 24 on the last -> res_class=24.
- Reset mid-op: assert rst during SETTLE, and separately during DONE -> all outputs return to 0 immediately; after release, ch0 is granted first.
- Stats (DTREE_SCHED_STATS_EN): 5 completed handshakes -> res_count=5; preload near saturation and complete 2 more -> res_count holds 16'hFFFF.
